// File: rtl/mte_sched_pkg.sv
// Shared types and constants for the MTE request scheduler.
package mte_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } sched_state_e;

   localparam int LATENCY_DEFAULT = 10;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mte_rr_arbiter.sv
// Request arbiter for the MTE scheduler: round-robin when MTE_SCHED_RR_EN is
// defined, fixed lowest-index priority otherwise.
module mte_rr_arbiter
   import mte_sched_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   input  logic            adv,
   output logic [NREQ-1:0] grant
);

`ifdef MTE_SCHED_RR_EN
   localparam int ID_W = id_width(NREQ);

   logic [ID_W-1:0] ptr_r;
   logic [ID_W-1:0] ptr_nx_s;
   logic [ID_W-1:0] idx_s;
   logic            found_s;
   logic            hit_s;

   // Scan from the pointer upward with wrap; first asserted request wins.
   always_comb begin
      grant    = '0;
      ptr_nx_s = ptr_r;
      idx_s    = '0;
      hit_s    = 1'b0;
      found_s  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s        = ID_W'((int'(ptr_r) + k) % NREQ);
         hit_s        = ~found_s & req[idx_s];
         grant[idx_s] = grant[idx_s] | hit_s;
         ptr_nx_s     = hit_s ? ID_W'((int'(idx_s) + 1) % NREQ) : ptr_nx_s;
         found_s      = found_s | hit_s;
      end
   end

   // Pointer moves past the winner only when its grant is actually taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r <= '0;
      end else if (adv) begin
         ptr_r <= ptr_nx_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end
`else
   logic unused_s;
   logic found_s;
   logic hit_s;

   assign unused_s = ^{clock, reset_n, adv};

   // Lowest asserted index wins.
   always_comb begin
      grant   = '0;
      hit_s   = 1'b0;
      found_s = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         hit_s    = ~found_s & req[k];
         grant[k] = hit_s;
         found_s  = found_s | hit_s;
      end
   end
`endif

endmodule

// File: rtl/mte_scheduler.sv
// Shares one externally instantiated MTE engine among NREQ requesters.
// Arbitration policy is selected by macro MTE_SCHED_RR_EN (see mte_rr_arbiter).
module mte_scheduler
   import mte_sched_pkg::*;
#(
   parameter int N       = 8,
   parameter int NREQ    = 2,
   parameter int LATENCY = LATENCY_DEFAULT
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*N-1:0]         req_key,
   input  logic [NREQ*N-1:0]         req_data,
   input  logic [NREQ-1:0]           req_sel,
   output logic [N-1:0]              eng_key,
   output logic [N-1:0]              eng_in,
   output logic                      eng_sel,
   input  logic [N-1:0]              eng_out,
   input  logic                      eng_valid_key,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [N-1:0]              rsp_data,
   output logic [id_width(NREQ)-1:0] rsp_id,
   output logic                      rsp_err,
   output logic                      busy
);

   localparam int         ID_W     = id_width(NREQ);
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   sched_state_e    state_r;
   sched_state_e    state_nx_s;
   logic [7:0]      cnt_r;
   logic [ID_W-1:0] owner_r;
   logic [ID_W-1:0] grant_id_s;
   logic [NREQ-1:0] grant_s;
   logic [N-1:0]    sel_key_s;
   logic [N-1:0]    sel_data_s;
   logic            sel_sel_s;
   logic            accept_s;
   logic            done_s;
   logic            rsp_hs_s;

   mte_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req_valid),
      .adv     (accept_s),
      .grant   (grant_s)
   );

   // Grant is gated by reset so req_ready reads zero while reset is held.
   assign req_ready = (state_r == IDLE && reset_n) ? grant_s : '0;
   assign accept_s  = |(req_valid & req_ready);
   assign done_s    = (state_r == RUN) && (cnt_r == 8'd0);
   assign rsp_hs_s  = (state_r == RESP) && rsp_ready;
   assign busy      = (state_r != IDLE);

   // Encode the one-hot grant and mux out the winner's request fields.
   always_comb begin
      grant_id_s = '0;
      sel_key_s  = '0;
      sel_data_s = '0;
      sel_sel_s  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         grant_id_s = grant_s[k] ? ID_W'(k)          : grant_id_s;
         sel_key_s  = grant_s[k] ? req_key[k*N +: N]  : sel_key_s;
         sel_data_s = grant_s[k] ? req_data[k*N +: N] : sel_data_s;
         sel_sel_s  = grant_s[k] ? req_sel[k]         : sel_sel_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE:    state_nx_s = accept_s ? RUN  : IDLE;
         RUN:     state_nx_s = done_s   ? RESP : RUN;
         RESP:    state_nx_s = rsp_hs_s ? IDLE : RESP;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Engine operands, latency counter and response capture.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         eng_key   <= '0;
         eng_in    <= '0;
         eng_sel   <= 1'b0;
         owner_r   <= '0;
         cnt_r     <= 8'd0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept_s) begin
            eng_key <= sel_key_s;
            eng_in  <= sel_data_s;
            eng_sel <= sel_sel_s;
            owner_r <= grant_id_s;
            cnt_r   <= CNT_LOAD;
         end else if (state_r == RUN && cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
         end
         if (done_s) begin
            rsp_valid <= 1'b1;
            rsp_data  <= eng_out;
            rsp_err   <= ~eng_valid_key;
            rsp_id    <= owner_r;
         end else if (rsp_hs_s) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mte_scheduler.sv
// Self-checking bench for mte_scheduler: transaction-level model plus
// directed vectors; expected grant order follows MTE_SCHED_RR_EN.
module tb_mte_scheduler;

   localparam int N       = 8;
   localparam int NREQ    = 2;
   localparam int LATENCY = 10;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_key;
   logic [NREQ*N-1:0] req_data;
   logic [NREQ-1:0]   req_sel;
   logic [N-1:0]      eng_key;
   logic [N-1:0]      eng_in;
   logic              eng_sel;
   logic [N-1:0]      eng_out;
   logic              eng_valid_key;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [N-1:0]      rsp_data;
   logic [0:0]        rsp_id;
   logic              rsp_err;
   logic              busy;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;
   int acc_id_q[$];
   int acc_cyc_q[$];
   int rsp_id_q[$];

   mte_scheduler #(.N(N), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_key       (req_key),
      .req_data      (req_data),
      .req_sel       (req_sel),
      .eng_key       (eng_key),
      .eng_in        (eng_in),
      .eng_sel       (eng_sel),
      .eng_out       (eng_out),
      .eng_valid_key (eng_valid_key),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_id        (rsp_id),
      .rsp_err       (rsp_err),
      .busy          (busy)
   );

   // Stand-in engine: encrypt = rotl3(d ^ k), decrypt = rotr3(d) ^ k.
   function automatic logic [7:0] mte_ref(input logic [7:0] k, input logic [7:0] d, input logic s);
      logic [7:0] x;
      if (s) begin
         x = d ^ k;
         return {x[4:0], x[7:5]};
      end
      x = {d[2:0], d[7:3]};
      return x ^ k;
   endfunction

   assign eng_out = mte_ref(eng_key, eng_in, eng_sel);

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int winner(input logic [NREQ-1:0] v, input int ptr);
`ifdef MTE_SCHED_RR_EN
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
`else
      for (int k = 0; k < NREQ; k++) begin
         if (v[k]) return k;
      end
`endif
      return -1;
   endfunction

   logic            m_run, m_rv, m_rerr, m_sel;
   logic [7:0]      m_rd, m_key, m_in;
   int              m_rid, m_owner, m_wait, m_ptr, m_win;
   logic [NREQ-1:0] m_exp_ready;

   assign m_win = winner(req_valid, m_ptr);

   always_comb begin
      m_exp_ready = '0;
      if (reset_n && !m_run && !m_rv && m_win >= 0) m_exp_ready[m_win] = 1'b1;
   end

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_run <= 1'b0; m_rv <= 1'b0; m_rerr <= 1'b0; m_sel <= 1'b0;
         m_rd <= 8'h00; m_key <= 8'h00; m_in <= 8'h00;
         m_rid <= 0; m_owner <= 0; m_wait <= 0; m_ptr <= 0;
      end else if (m_rv) begin
         if (rsp_ready) m_rv <= 1'b0;
      end else if (m_run) begin
         if (m_wait == 1) begin
            m_run  <= 1'b0;
            m_rv   <= 1'b1;
            m_rd   <= mte_ref(m_key, m_in, m_sel);
            m_rerr <= ~eng_valid_key;
            m_rid  <= m_owner;
         end
         m_wait <= m_wait - 1;
      end else if (m_win >= 0) begin
         m_key   <= req_key[m_win*N +: N];
         m_in    <= req_data[m_win*N +: N];
         m_sel   <= req_sel[m_win];
         m_owner <= m_win;
         m_wait  <= LATENCY;
         m_run   <= 1'b1;
         m_ptr   <= (m_win + 1) % NREQ;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clock) begin
      check("cmp_req_ready", req_ready, m_exp_ready);
      check("cmp_busy",      busy,      m_run | m_rv);
      check("cmp_rsp_valid", rsp_valid, m_rv);
      check("cmp_rsp_data",  rsp_data,  m_rd);
      check("cmp_rsp_id",    rsp_id,    m_rid);
      check("cmp_rsp_err",   rsp_err,   m_rerr);
      check("cmp_eng_key",   eng_key,   m_key);
      check("cmp_eng_in",    eng_in,    m_in);
      check("cmp_eng_sel",   eng_sel,   m_sel);
   end

   // Handshake logger: grants with their edge index, and response ids.
   always @(posedge clock) begin
      if (reset_n) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               acc_id_q.push_back(i);
               acc_cyc_q.push_back(cyc);
            end
         end
         if (rsp_valid && rsp_ready) rsp_id_q.push_back(int'(rsp_id));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic set_req(input int i, input logic [7:0] k, input logic [7:0] d, input logic s);
      req_key[i*N +: N]  = k;
      req_data[i*N +: N] = d;
      req_sel[i]         = s;
   endtask

   task automatic do_req(input string name, input int i, input logic [7:0] k, input logic [7:0] d,
                         input logic s, output int acc);
      int n;
      n   = acc_cyc_q.size();
      acc = -1;
      set_req(i, k, d, s);
      req_valid[i] = 1'b1;
      for (int t = 0; t < 30 && acc_cyc_q.size() == n; t++) begin
         @(posedge clock);
         #1;
      end
      req_valid[i] = 1'b0;
      if (acc_cyc_q.size() > n) acc = acc_cyc_q[$];
      else check({name, "_accept_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input string name, output int edge_idx);
      edge_idx = -1;
      for (int t = 0; t < 40 && edge_idx < 0; t++) begin
         @(posedge clock);
         #1;
         if (rsp_valid) edge_idx = cyc - 1;
      end
      if (edge_idx < 0) check({name, "_rsp_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic finish_rsp(input string name);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      check({name, "_hs_clear"}, rsp_valid, 1'b0);
   endtask

   initial begin
      int acc, rise, h;
      req_valid = '0; req_key = '0; req_data = '0; req_sel = '0;
      rsp_ready = 1'b0; eng_valid_key = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_busy",      busy,      1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_data",  rsp_data,  8'h00);
      check("rst_eng_key",   eng_key,   8'h00);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // Single encrypt on requester 0.
      do_req("t1", 0, 8'h13, 8'hFF, 1'b1, acc);
      check("t1_busy", busy, 1'b1);
      wait_rsp("t1", rise);
      check("t1_latency", 32'(rise - acc), 32'd10);
      check("t1_id",   rsp_id,   1'b0);
      check("t1_data", rsp_data, 8'h67);
      check("t1_err",  rsp_err,  1'b0);
      finish_rsp("t1");

      // Backpressure: response held 5 cycles while requester 0 waits.
      do_req("bp", 1, 8'h0F, 8'h06, 1'b0, acc);
      set_req(0, 8'h0F, 8'h02, 1'b1);
      req_valid[0] = 1'b1;
      wait_rsp("bp", rise);
      for (int t = 0; t < 5; t++) begin
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_data",  rsp_data,  8'hCF);
         check("bp_id",    rsp_id,    1'b1);
         check("bp_err",   rsp_err,   1'b0);
         check("bp_ready", req_ready, 2'b00);
         @(posedge clock);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      h = cyc - 1;
      rsp_ready = 1'b0;
      check("bp_hs_clear", rsp_valid, 1'b0);
      check("bp_idle_ready", req_ready, 2'b01);
      @(posedge clock);
      #1;
      req_valid = '0;
      check("bp_next_accept", 32'(acc_cyc_q[$]), 32'(h + 1));
      wait_rsp("bp2", rise);
      check("bp2_data", rsp_data, 8'h68);
      check("bp2_id",   rsp_id,   1'b0);
      finish_rsp("bp2");

      // Invalid key still completes a normal handshake.
      eng_valid_key = 1'b0;
      do_req("ke", 0, 8'h0A, 8'h05, 1'b1, acc);
      wait_rsp("ke", rise);
      check("ke_latency", 32'(rise - acc), 32'd10);
      check("ke_err",  rsp_err,  1'b1);
      check("ke_data", rsp_data, 8'h78);
      finish_rsp("ke");
      check("ke_busy_after", busy, 1'b0);
      eng_valid_key = 1'b1;

      // Reset in the middle of RUN discards the operation.
      do_req("rr", 0, 8'h13, 8'hFF, 1'b0, acc);
      repeat (4) begin
         @(posedge clock);
         #1;
      end
      set_req(1, 8'h13, 8'hFF, 1'b1);
      req_valid = 2'b10;
      #2 reset_n = 1'b0;
      #1;
      check("rr_busy",      busy,      1'b0);
      check("rr_rsp_valid", rsp_valid, 1'b0);
      check("rr_req_ready", req_ready, 2'b00);
      check("rr_eng_key",   eng_key,   8'h00);
      check("rr_eng_in",    eng_in,    8'h00);
      check("rr_eng_sel",   eng_sel,   1'b0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      do_req("rr2", 1, 8'h13, 8'hFF, 1'b1, acc);
      wait_rsp("rr2", rise);
      check("rr2_latency", 32'(rise - acc), 32'd10);
      check("rr2_id",   rsp_id,   1'b1);
      check("rr2_data", rsp_data, 8'h67);
      finish_rsp("rr2");

      // Both requesters held: grant order depends on arbitration policy.
      acc_id_q.delete();
      rsp_id_q.delete();
      set_req(0, 8'h0F, 8'h02, 1'b1);
      set_req(1, 8'h0F, 8'h06, 1'b0);
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      for (int t = 0; t < 120 && acc_id_q.size() < 4; t++) begin
         @(posedge clock);
         #1;
      end
      req_valid = '0;
      for (int t = 0; t < 40 && rsp_id_q.size() < 4; t++) begin
         @(posedge clock);
         #1;
      end
      rsp_ready = 1'b0;
      check("arb_accepts", 32'(acc_id_q.size()), 32'd4);
      check("arb_rsps",    32'(rsp_id_q.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
`ifdef MTE_SCHED_RR_EN
         if (k < acc_id_q.size()) check("arb_grant_rr", 32'(acc_id_q[k]), 32'(k % 2));
         if (k < rsp_id_q.size()) check("arb_rspid_rr", 32'(rsp_id_q[k]), 32'(k % 2));
`else
         if (k < acc_id_q.size()) check("arb_grant_fixed", 32'(acc_id_q[k]), 32'd0);
         if (k < rsp_id_q.size()) check("arb_rspid_fixed", 32'(rsp_id_q[k]), 32'd0);
`endif
      end

      repeat (2) @(posedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", errs);
      $fatal(1);
   end

endmodule

// File: doc/mte_scheduler.md
MTE_SCHEDULER -- requirements
Module: mte_scheduler

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the key and data width in bits.
REQ-002 The module SHALL have parameter NREQ, default 2, legal range 2..4, giving the number of requesters.
REQ-003 The module SHALL have parameter LATENCY, default 10, legal range 1..255, giving the cycles the MTE engine inputs are held before OUT is sampled.
REQ-004 The module SHALL have these ports, in this order:
  clock  in  1  sole clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  req_valid  in  NREQ  per-requester request valid.
  req_ready  out  NREQ  per-requester accept.
  req_key  in  NREQ×N  per-requester key.
  req_data  in  NREQ×N  per-requester plaintext or ciphertext.
  req_sel  in  NREQ  1 = encrypt, 0 = decrypt.
  eng_key  out  N  drives MTE key.
  eng_in  out  N  drives MTE IN.
  eng_sel  out  1  drives MTE sel.
  eng_out  in  N  MTE OUT.
  eng_valid_key  in  1  MTE valid_key.
  rsp_valid  out  1  result valid.
  rsp_ready  in  1  result accept.
  rsp_data  out  N  engine result.
  rsp_id  out  clog2(NREQ)  index of the requester that owns the result.
  rsp_err  out  1  1 = eng_valid_key was low at sample time.
  busy  out  1  high whenever the state is not IDLE.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, RUN and RESP.
REQ-006 In IDLE, req_ready SHALL be one-hot on the arbitration winner among the asserted req_valid bits, and all zero when no req_valid bit is set.
REQ-007 In RUN and RESP, req_ready SHALL be all zero.
REQ-008 On an accept edge (req_valid[i] & req_ready[i]), the block SHALL register eng_key, eng_in and eng_sel from requester i, store i as the owner id, load the cycle counter with LATENCY-1, and go to RUN.
REQ-009 In RUN, eng_key, eng_in and eng_sel SHALL hold constant.
REQ-010 In RUN, the counter SHALL decrement once per edge.
REQ-011 On the RUN edge at which the counter is 0, the block SHALL capture rsp_data = eng_out and rsp_err = ~eng_valid_key, drive rsp_id = owner, set rsp_valid = 1, and go to RESP.
REQ-012 rsp_valid SHALL therefore rise exactly LATENCY edges after the accept edge.
REQ-013 In RESP, rsp_valid, rsp_data, rsp_id and rsp_err SHALL hold until the edge at which rsp_ready = 1.
REQ-014 At that rsp_ready edge, the block SHALL clear rsp_valid and go to IDLE.
REQ-015 After a response handshake, the next accept SHALL occur no earlier than the following edge, giving a one-cycle bubble minimum.
REQ-016 Outside an accept edge, eng_key, eng_in and eng_sel SHALL retain their last values.
REQ-017 Changes on req_* while in RUN or RESP SHALL have no effect.
REQ-018 When LATENCY = 1, the block SHALL enter RESP on the first edge after the accept edge.
REQ-019 rsp_err = 1 SHALL still produce a normal response handshake; no retry is performed.

Reset
REQ-020 Assertion of reset_n = 0 SHALL asynchronously force state = IDLE and counter = 0.
REQ-021 Assertion of reset_n = 0 SHALL asynchronously force req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, eng_key = 0, eng_in = 0, eng_sel = 0, busy = 0 and the round-robin pointer = 0.
REQ-022 Reset asserted in RUN or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-023 The first accept after reset_n rises SHALL occur no earlier than the first rising clock edge with reset_n = 1.

Configuration
REQ-024 With macro MTE_SCHED_RR_EN defined, arbitration SHALL be round-robin.
REQ-025 Under MTE_SCHED_RR_EN, after requester i is granted, the search SHALL start at requester (i+1) mod NREQ.
REQ-026 Without MTE_SCHED_RR_EN, arbitration SHALL be fixed priority, with the lowest index winning, and the pointer logic SHALL be absent.

Structure
REQ-027 Package mte_sched_pkg SHALL hold the state enum (IDLE, RUN, RESP), the default LATENCY constant and the id-width helper function.
REQ-028 Arbitration SHALL reside in sub-module mte_rr_arbiter (inputs: request vector, advance strobe; output: one-hot grant), containing both the MTE_SCHED_RR_EN and fixed-priority variants.
REQ-029 The MTE engine SHALL be instantiated outside this block; only its ports are driven and sampled.

Verification
REQ-030 Single encrypt: req0 with key 0x13, data 0xFF, sel 1 -> rsp_valid exactly 10 cycles after accept; rsp_id 0; rsp_data equals the engine reference model value; rsp_err 0.
REQ-031 Round-robin, MTE_SCHED_RR_EN defined: req0 (key 0x0F, data 0x02, sel 1) and req1 (key 0x0F, data 0x06, sel 0) asserted together and held -> grant order 0, 1, 0, 1; responses carry matching ids.
REQ-032 Fixed priority, macro undefined: same stimulus as REQ-031 -> req0 granted every time; req1 starves while req0 remains valid.
REQ-033 Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_* stable for those 5 cycles; req_ready stays 0; the next accept occurs one cycle after the handshake.
REQ-034 Key error: eng_valid_key forced 0 with key 0x0A, data 0x05 -> response with rsp_err 1, normal handshake completes.
REQ-035 Reset mid-RUN: reset_n pulsed low at cycle 4 of RUN -> all outputs 0 immediately, no response emitted, and a fresh request afterwards completes in 10 cycles.
